// File: rtl/rob_multiway.sv
// rob_multiway: multi-lane reorder buffer with in-order retirement and branch rollback.
// Ports:
//   clock, reset (async, active low), en (0 freezes all state)
//   dispatch_en/_T/_Told/_dest/_halt : up to WAY in-order allocations at the tail
//   complete_en/_idx                 : up to WAY completion marks by entry index
//   rollback_en/_idx                 : flush every entry younger than rollback_idx
//   free_slots, tail_idx             : dispatch capacity and entry index per lane
//   retire_en/_T/_Told/_dest         : up to WAY in-order retirements at the head
//   halt_out                         : a halt entry retires this cycle
//   count                            : occupied entries
module rob_multiway #(
    parameter int unsigned NUM_ROB = 32,
    parameter int unsigned WAY     = 2,
    parameter int unsigned PR_W    = 6,
    parameter int unsigned AR_W    = 5,
    parameter int unsigned IDX_W   = $clog2(NUM_ROB)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WAY-1:0]           dispatch_en,
    input  logic [WAY*PR_W-1:0]      dispatch_T,
    input  logic [WAY*PR_W-1:0]      dispatch_Told,
    input  logic [WAY*AR_W-1:0]      dispatch_dest,
    input  logic [WAY-1:0]           dispatch_halt,
    input  logic [WAY-1:0]           complete_en,
    input  logic [WAY*IDX_W-1:0]     complete_idx,
    input  logic                     rollback_en,
    input  logic [IDX_W-1:0]         rollback_idx,
    output logic [$clog2(WAY+1)-1:0] free_slots,
    output logic [WAY*IDX_W-1:0]     tail_idx,
    output logic [WAY-1:0]           retire_en,
    output logic [WAY*PR_W-1:0]      retire_T,
    output logic [WAY*PR_W-1:0]      retire_Told,
    output logic [WAY*AR_W-1:0]      retire_dest,
    output logic                     halt_out,
    output logic [IDX_W:0]           count
);
    localparam int unsigned FS_W  = $clog2(WAY + 1);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;
    logic               halted;
    logic [NUM_ROB-1:0] valid;
    logic [NUM_ROB-1:0] complete;
    logic [NUM_ROB-1:0] halt;
    logic [PR_W-1:0]    ent_t    [NUM_ROB];
    logic [PR_W-1:0]    ent_told [NUM_ROB];
    logic [AR_W-1:0]    ent_dest [NUM_ROB];

    logic [FS_W-1:0]    disp_k;
    logic [FS_W-1:0]    ret_n;
    logic               rb_ok;
    logic [IDX_W-1:0]   rb_off;
    logic [NUM_ROB-1:0] valid_n;
    logic [NUM_ROB-1:0] complete_n;
    logic [NUM_ROB-1:0] halt_n;
    logic [IDX_W-1:0]   head_n;
    logic [IDX_W-1:0]   tail_n;
    logic [CNT_W-1:0]   count_n;

    // Dispatch capacity from registered occupancy; retiring entries do not free slots early.
    always_comb begin
        logic [CNT_W-1:0] room;
        room       = CNT_W'(NUM_ROB) - count;
        free_slots = '0;
        if (en && !halted && !rollback_en) begin
            if (room >= CNT_W'(WAY)) free_slots = FS_W'(WAY);
            else                     free_slots = FS_W'(room);
        end
    end

    // Accepted dispatch lanes: contiguous prefix from lane 0, capped by capacity.
    always_comb begin
        logic run;
        run    = 1'b1;
        disp_k = '0;
        for (int i = 0; i < WAY; i++) begin
            run = run && dispatch_en[i] && (FS_W'(i) < free_slots);
            if (run) disp_k = disp_k + FS_W'(1);
        end
    end

    always_comb begin
        tail_idx = '0;
        for (int i = 0; i < WAY; i++) tail_idx[i*IDX_W +: IDX_W] = tail + IDX_W'(i);
    end

    // In-order retire: a lane retires only if every older lane retires and none of them is a halt.
    always_comb begin
        logic             run;
        logic [IDX_W-1:0] p;
        run         = en && !halted;
        ret_n       = '0;
        halt_out    = 1'b0;
        retire_en   = '0;
        retire_T    = '0;
        retire_Told = '0;
        retire_dest = '0;
        for (int i = 0; i < WAY; i++) begin
            p   = head + IDX_W'(i);
            run = run && valid[p] && complete[p];
            retire_en[i]                  = run;
            retire_T[i*PR_W +: PR_W]      = ent_t[p];
            retire_Told[i*PR_W +: PR_W]   = ent_told[p];
            retire_dest[i*AR_W +: AR_W]   = ent_dest[p];
            if (run) begin
                ret_n = ret_n + FS_W'(1);
                if (halt[p]) halt_out = 1'b1;
            end
            run = run && !halt[p];
        end
    end

    // Next entry flags and pointers; rollback flushes by age relative to head.
    always_comb begin
        logic [IDX_W-1:0] p;
        rb_ok      = en && rollback_en && valid[rollback_idx];
        rb_off     = rollback_idx - head;
        valid_n    = valid;
        complete_n = complete;
        halt_n     = halt;
        for (int i = 0; i < WAY; i++) begin
            p = complete_idx[i*IDX_W +: IDX_W];
            if (complete_en[i] && valid[p]) complete_n[p] = 1'b1;
        end
        for (int i = 0; i < WAY; i++) begin
            p = head + IDX_W'(i);
            if (retire_en[i]) valid_n[p] = 1'b0;
        end
        for (int i = 0; i < WAY; i++) begin
            p = tail + IDX_W'(i);
            if (FS_W'(i) < disp_k) begin
                valid_n[p]    = 1'b1;
                complete_n[p] = 1'b0;
                halt_n[p]     = dispatch_halt[i];
            end
        end
        if (rb_ok) begin
            for (int j = 0; j < NUM_ROB; j++) begin
                p = IDX_W'(j) - head;
                if (p > rb_off) valid_n[j] = 1'b0;
            end
        end
        head_n = head + IDX_W'(ret_n);
        if (rb_ok) begin
            tail_n  = rollback_idx + IDX_W'(1);
            count_n = CNT_W'(rb_off) + CNT_W'(1) - CNT_W'(ret_n);
        end else begin
            tail_n  = tail + IDX_W'(disp_k);
            count_n = count + CNT_W'(disp_k) - CNT_W'(ret_n);
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted   <= 1'b0;
            valid    <= '0;
            complete <= '0;
            halt     <= '0;
            for (int j = 0; j < NUM_ROB; j++) begin
                ent_t[j]    <= '0;
                ent_told[j] <= '0;
                ent_dest[j] <= '0;
            end
        end else if (en) begin
            head     <= head_n;
            tail     <= tail_n;
            count    <= count_n;
            halted   <= halted || halt_out;
            valid    <= valid_n;
            complete <= complete_n;
            halt     <= halt_n;
            for (int i = 0; i < WAY; i++) begin
                if (FS_W'(i) < disp_k) begin
                    ent_t[tail + IDX_W'(i)]    <= dispatch_T[i*PR_W +: PR_W];
                    ent_told[tail + IDX_W'(i)] <= dispatch_Told[i*PR_W +: PR_W];
                    ent_dest[tail + IDX_W'(i)] <= dispatch_dest[i*AR_W +: AR_W];
                end
            end
        end
    end

endmodule
